muldiv_unit: RTL and testbench

- Multi-cycle 64-bit integer multiply/divide unit for LEGv8 MUL, UMULH, UDIV and SDIV.
- Sits directly downstream of the register file.
  - Consumes its two read ports (read_1 → operand_a, read_2 → operand_b) plus the destination register address.
  - Produces a result with a one-cycle write-enable pulse that drives the register file write port (write_data, write_add, write_en).
- The core stalls on busy while an operation runs.

---
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle 64-bit multiply/divide unit (MUL, UMULH, UDIV, SDIV) feeding the register file write port.
// Shift-add multiply and restoring divide share one hi/lo working register pair.
module muldiv_unit #(
   parameter int WIDTH  = 64,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [WIDTH-1:0]  operand_a,
   input  logic [WIDTH-1:0]  operand_b,
   input  logic [ADDR_W-1:0] dest_in,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic [ADDR_W-1:0] dest_out,
   output logic [1:0]        dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_UMULH = 2'b01;
   localparam logic [1:0] OP_UDIV  = 2'b10;
   localparam logic [1:0] OP_SDIV  = 2'b11;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t              state;
   logic [1:0]          op_q;
   logic [WIDTH-1:0]    a_q, b_q, m_q, hi, lo;
   logic [ADDR_W-1:0]   dest_q;
   logic [CNT_W-1:0]    cnt;
   logic                setup_q, neg_q, div0_q;

   logic                is_div, quot_bit;
   logic [WIDTH:0]      mul_sum, rem_sh;
   logic [WIDTH-1:0]    sub, hi_n, lo_n, a_mag, b_mag, final_res;

   assign dbg_state = state;
   assign is_div    = op_q[1];

   // Magnitudes are taken in the first RUN cycle so the register-file read path stays short.
   assign a_mag = (op_q == OP_SDIV && a_q[WIDTH-1]) ? -a_q : a_q;
   assign b_mag = (op_q == OP_SDIV && b_q[WIDTH-1]) ? -b_q : b_q;

   always_comb begin
      mul_sum  = '0;
      rem_sh   = '0;
      sub      = '0;
      quot_bit = 1'b0;
      hi_n     = hi;
      lo_n     = lo;
      if (!is_div) begin
         mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
         hi_n    = mul_sum[WIDTH:1];
         lo_n    = {mul_sum[0], lo[WIDTH-1:1]};
      end else begin
         rem_sh   = {hi, lo[WIDTH-1]};
         quot_bit = (rem_sh >= {1'b0, m_q});
         sub      = rem_sh[WIDTH-1:0] - m_q;
         hi_n     = quot_bit ? sub : rem_sh[WIDTH-1:0];
         lo_n     = {lo[WIDTH-2:0], quot_bit};
      end
   end

   always_comb begin
      final_res = '0;
      case (op_q)
         OP_MUL:   final_res = lo_n;
         OP_UMULH: final_res = hi_n;
         OP_UDIV:  final_res = div0_q ? '0 : lo_n;
         default:  final_res = div0_q ? '0 : (neg_q ? -lo_n : lo_n);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         dest_out <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         hi       <= '0;
         lo       <= '0;
         dest_q   <= '0;
         cnt      <= '0;
         setup_q  <= 1'b0;
         neg_q    <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_q    <= op;
                  a_q     <= operand_a;
                  b_q     <= operand_b;
                  dest_q  <= dest_in;
                  cnt     <= CNT_W'(WIDTH - 1);
                  setup_q <= 1'b1;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (setup_q) begin
                  setup_q <= 1'b0;
                  hi      <= '0;
                  lo      <= is_div ? a_mag : b_q;
                  m_q     <= is_div ? b_mag : a_q;
                  neg_q   <= (op_q == OP_SDIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                  div0_q  <= (b_q == '0);
               end else begin
                  hi  <= hi_n;
                  lo  <= lo_n;
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) begin
                     result   <= final_res;
                     dest_out <= dest_q;
                     done     <= 1'b1;
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results, a done-triggered monitor pops and compares.
module tb_muldiv_unit;

   localparam int W  = 64;
   localparam int AW = 5;
   localparam int EW = W + AW;
   localparam logic [W-1:0] S_MIN = 64'h8000_0000_0000_0000;

   logic          clk, reset, start, busy, done;
   logic [1:0]    op;
   logic [W-1:0]  operand_a, operand_b, result;
   logic [AW-1:0] dest_in, dest_out;
   logic [1:0]    dbg_state;

   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   muldiv_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .dest_in(dest_in),
      .busy(busy), .done(done), .result(result), .dest_out(dest_out),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Reference model: plain arithmetic on wide / signed integers.
   function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      longint sa, sb, sq;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      case (o)
         2'b00: return p[W-1:0];
         2'b01: return p[2*W-1:W];
         2'b10: return (b == '0) ? '0 : a / b;
         default: begin
            if (b == '0) return '0;
            if (a == S_MIN && b == '1) return S_MIN;
            sa = a;
            sb = b;
            sq = sa / sb;
            return sq;
         end
      endcase
   endfunction

   // monitor
   always @(negedge clk) begin
      if (!reset && done) begin
         check(exp_q.size() != 0, "unexpected_done", 128'(result), 128'(0));
         if (exp_q.size() != 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check({dest_out, result} == e, "result", 128'({dest_out, result}), 128'(e));
         end
      end
   end

   function automatic logic [W-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // driver
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] d, input bit inject);
      int cyc;
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b; dest_in = d;
      exp_q.push_back({d, ref_model(o, a, b)});
      @(posedge clk); #1;
      cyc = 1;
      start = 1'b0;
      op = 2'($urandom_range(0, 3)); operand_a = rnd64(); operand_b = rnd64(); dest_in = AW'($urandom());
      check(busy == 1'b1, "busy_rise", 128'(busy), 128'(1));
      while (!done && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (inject && cyc == 20) begin
            start = 1'b1; operand_a = rnd64(); operand_b = rnd64();
         end else if (cyc == 21) begin
            start = 1'b0;
         end
      end
      check(cyc == 66, "latency", 128'(cyc), 128'(66));
      if (inject) begin
         start = 1'b1; operand_a = rnd64(); operand_b = rnd64(); dest_in = AW'($urandom());
      end
      @(posedge clk); #1;
      start = 1'b0;
      check(busy == 1'b0 && done == 1'b0, "idle_after_done", 128'({busy, done}), 128'(0));
   endtask

   initial begin
      logic [W-1:0] a, b;
      start = 1'b0; op = '0; operand_a = '0; operand_b = '0; dest_in = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check({busy, done, result, dest_out} == '0, "reset_state",
            128'({busy, done, result, dest_out}), 128'(0));
      @(negedge clk);
      reset = 1'b0;

      run_op(2'b00, 64'd7, 64'd6, 5'd9, 1'b0);
      run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 1'b0);
      run_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 1'b0);
      run_op(2'b10, 64'd100, 64'd7, 5'd3, 1'b0);
      run_op(2'b10, 64'd5, 64'd0, 5'd4, 1'b0);
      run_op(2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd5, 1'b0);
      run_op(2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd6, 1'b0);
      run_op(2'b11, S_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1'b0);
      run_op(2'b11, 64'd17, 64'd0, 5'd8, 1'b0);
      run_op(2'b00, 64'd123, 64'd456, 5'd10, 1'b1);
      run_op(2'b10, rnd64(), 64'd13, 5'd11, 1'b0);

      // reset in the middle of an operation
      @(negedge clk);
      start = 1'b1; op = 2'b00; operand_a = 64'd99; operand_b = 64'd99; dest_in = 5'd12;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check({busy, done, result, dest_out} == '0, "reset_midop",
            128'({busy, done, result, dest_out}), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      check(busy == 1'b0, "no_resume_after_reset", 128'(busy), 128'(0));

      run_op(2'b00, 64'd3, 64'd4, 5'd13, 1'b0);

      for (int i = 0; i < 20; i++) begin
         a = rnd64();
         case ($urandom_range(0, 3))
            0: b = rnd64();
            1: b = 64'($urandom_range(1, 1000));
            2: b = '0;
            default: b = '1;
         endcase
         if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(1, 63);
         run_op(2'($urandom_range(0, 3)), a, b, AW'($urandom()), i[0]);
      end

      repeat (5) @(posedge clk);
      #1;
      check(exp_q.size() == 0, "queue_empty", 128'(exp_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
